// File: rtl/ace_ccu_snoop_resp_collector.sv
// ace_ccu_snoop_resp_collector
//   Collects the snoop response for one outstanding snoop at a time: accepts the
//   CR response, forwards an optional CD burst to the CCU data path without
//   buffering, and then presents one summary result that the CCU FSM uses to
//   choose between cache-to-cache data and a memory fetch.
//
// Ports
//   clk, rst_n                    clock; asynchronous reset, asserted high
//   cmd_valid_i/ready_o/len_i     snoop issued, with expected CD beats minus one
//   cr_valid_i/ready_o/resp_i     snoop response {WasUnique,IsShared,PassDirty,Error,DataTransfer}
//   cd_valid_i/ready_o/data_i/last_i    snoop data beat from the interconnect
//   data_valid_o/ready_i/o/last_o       forwarded data beat to the CCU data path
//   res_valid_o/ready_i           summary handshake
//   res_data_o/dirty_o/shared_o/err_o   summary flags
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no snoop outstanding, accepts cmd
// WAIT_CR   | snoop issued, waiting for the CR response
// DATA      | CR said DataTransfer, passing CD beats through until cd_last
// RESULT    | summary presented until accepted

module ace_ccu_snoop_resp_collector #(
    parameter int DataWidth = 64,
    parameter int LenWidth  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [LenWidth-1:0]  cmd_len_i,
    input  logic                 cr_valid_i,
    output logic                 cr_ready_o,
    input  logic [4:0]           cr_resp_i,
    input  logic                 cd_valid_i,
    output logic                 cd_ready_o,
    input  logic [DataWidth-1:0] cd_data_i,
    input  logic                 cd_last_i,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_last_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic                 res_data_o,
    output logic                 res_dirty_o,
    output logic                 res_shared_o,
    output logic                 res_err_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_CR = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;
    localparam logic [1:0] ST_RESULT  = 2'd3;

    localparam logic [LenWidth:0] CntMax = '1;
    localparam logic [LenWidth:0] CntOne = {{LenWidth{1'b0}}, 1'b1};

    logic [1:0]          state_q;
    logic [LenWidth-1:0] len_q;
    logic [4:0]          res_q;
    logic [LenWidth:0]   cnt_q;
    logic                len_err_q;

    logic in_idle, in_wait_cr, in_data, in_result;
    logic cd_hs;
    logic unused_was_unique;

    assign in_idle    = (state_q == ST_IDLE);
    assign in_wait_cr = (state_q == ST_WAIT_CR);
    assign in_data    = (state_q == ST_DATA);
    assign in_result  = (state_q == ST_RESULT);

    // The state register already sits in IDLE during reset; the extra rst_n term
    // keeps cmd_ready low until reset is actually released.
    assign cmd_ready_o  = in_idle & ~rst_n;
    assign cr_ready_o   = in_wait_cr;

    // Pure pass-through in DATA. Payload is gated so nothing leaks outside the burst.
    assign cd_ready_o   = in_data & data_ready_i;
    assign data_valid_o = in_data & cd_valid_i;
    assign data_o       = in_data ? cd_data_i : '0;
    assign data_last_o  = in_data & cd_last_i;
    assign cd_hs        = in_data & cd_valid_i & data_ready_i;

    assign res_valid_o  = in_result;
    assign res_data_o   = in_result & res_q[0];
    assign res_dirty_o  = in_result & res_q[2];
    assign res_shared_o = in_result & res_q[3];
    assign res_err_o    = in_result & (res_q[1] | len_err_q);

    // WasUnique is captured with the rest of the response but not summarised.
    assign unused_was_unique = res_q[4];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        len_q     <= cmd_len_i;
                        res_q     <= '0;
                        len_err_q <= 1'b0;
                        state_q   <= ST_WAIT_CR;
                    end
                end
                ST_WAIT_CR: begin
                    if (cr_valid_i) begin
                        res_q   <= cr_resp_i;
                        cnt_q   <= '0;
                        state_q <= cr_resp_i[0] ? ST_DATA : ST_RESULT;
                    end
                end
                ST_DATA: begin
                    if (cd_hs) begin
                        if (cnt_q != CntMax) begin
                            cnt_q <= cnt_q + CntOne;
                        end
                        // Compare against the count before this beat: len is beats-1.
                        if (cd_last_i) begin
                            len_err_q <= (cnt_q != {1'b0, len_q});
                            state_q   <= ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (res_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
